// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares one DMI request/response channel between NrMasters
// requesters. Round-robin grant, one transaction in flight, and the response
// is routed back only to the requester that owns the transaction.
// Request layout {addr[6:0], op[1:0], data[31:0]}; response {data[31:0], resp[1:0]}.
module dmi_arbiter #(
    parameter  int unsigned NrMasters = 2,
    localparam int unsigned IdxW      = $clog2(NrMasters)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NrMasters-1:0][40:0]    mst_req_i,
    input  logic [NrMasters-1:0]          mst_req_valid_i,
    output logic [NrMasters-1:0]          mst_req_ready_o,
    output logic [NrMasters-1:0][33:0]    mst_resp_o,
    output logic [NrMasters-1:0]          mst_resp_valid_o,
    input  logic [NrMasters-1:0]          mst_resp_ready_i,
    output logic [40:0]                   slv_req_o,
    output logic                          slv_req_valid_o,
    input  logic                          slv_req_ready_i,
    input  logic [33:0]                   slv_resp_i,
    input  logic                          slv_resp_valid_i,
    output logic                          slv_resp_ready_o,
    output logic                          busy_o,
    output logic [IdxW-1:0]               owner_o
);

    localparam int unsigned IdxW1 = IdxW + 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e          state_q;
    logic [40:0]     req_q;
    logic [IdxW-1:0] owner_q;
    logic [IdxW-1:0] prio_q;

    logic            w_found;
    logic [IdxW-1:0] w_win;
    logic [IdxW:0]   w_idx;
    logic [IdxW-1:0] w_owner_nxt;

    // Round-robin pick: first valid at or after prio_q, wrapping mod NrMasters.
    // The sum is one bit wider so the wrap works for non-power-of-2 counts.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NrMasters; i++) begin
            w_idx = {1'b0, prio_q} + IdxW1'(i);
            if (w_idx >= IdxW1'(NrMasters)) begin
                w_idx = w_idx - IdxW1'(NrMasters);
            end
            if (!w_found && mst_req_valid_i[w_idx[IdxW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IdxW-1:0];
            end
        end
    end

    // Explicit wrap so the pointer never lands on a nonexistent requester
    assign w_owner_nxt = (owner_q == IdxW'(NrMasters - 1)) ? '0 : owner_q + 1'b1;

    // Grant only in IDLE; ready depends on valids, never the other way round
    always_comb begin
        mst_req_ready_o = '0;
        if (state_q == IDLE && w_found) begin
            mst_req_ready_o[w_win] = 1'b1;
        end
    end

    // Response is passed straight through, but only to the owner and only in RESP;
    // anything arriving earlier stays back-pressured at the slave
    always_comb begin
        mst_resp_valid_o = '0;
        if (state_q == RESP) begin
            mst_resp_valid_o[owner_q] = slv_resp_valid_i;
        end
    end

    // Response payload is broadcast; the valid bit alone selects the receiver
    always_comb begin
        for (int unsigned i = 0; i < NrMasters; i++) begin
            mst_resp_o[i] = slv_resp_i;
        end
    end

    assign slv_resp_ready_o = (state_q == RESP) && mst_resp_ready_i[owner_q];
    assign slv_req_valid_o  = (state_q == REQ);
    assign slv_req_o        = req_q;
    assign busy_o           = (state_q != IDLE);
    assign owner_o          = owner_q;

    // Transaction FSM: capture the winner's request, present it, wait for the reply
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            owner_q <= '0;
            prio_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        req_q   <= mst_req_i[w_win];
                        owner_q <= w_win;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (slv_req_ready_i) begin
                        prio_q  <= w_owner_nxt;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (slv_resp_valid_i && slv_resp_ready_o) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level round-robin model.
module tb_dmi_arbiter;

    localparam int N = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0][40:0] mreq = '0;
    logic [N-1:0]      mvalid = '0;
    logic [N-1:0]      mready;
    logic [N-1:0][33:0] mresp;
    logic [N-1:0]      mresp_valid;
    logic [N-1:0]      mresp_ready = '0;
    logic [40:0]       sreq;
    logic              sreq_valid;
    logic              sreq_ready = 1'b0;
    logic [33:0]       sresp = '0;
    logic              sresp_valid = 1'b0;
    logic              sresp_ready;
    logic              busy;
    logic [0:0]        owner;

    int n_tests = 0;
    int n_fail  = 0;

    dmi_arbiter #(.NrMasters(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mst_req_i(mreq), .mst_req_valid_i(mvalid), .mst_req_ready_o(mready),
        .mst_resp_o(mresp), .mst_resp_valid_o(mresp_valid), .mst_resp_ready_i(mresp_ready),
        .slv_req_o(sreq), .slv_req_valid_o(sreq_valid), .slv_req_ready_i(sreq_ready),
        .slv_resp_i(sresp), .slv_resp_valid_i(sresp_valid), .slv_resp_ready_o(sresp_ready),
        .busy_o(busy), .owner_o(owner)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        mreq = '0; mvalid = '0; mresp_ready = '0;
        sreq_ready = 1'b0; sresp = '0; sresp_valid = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    function automatic logic [40:0] rnd_req();
        logic [6:0]  a;
        logic [1:0]  o;
        logic [31:0] d;
        a = 7'($urandom); o = 2'($urandom); d = $urandom;
        return {a, o, d};
    endfunction

    // One full transaction from requester idx with everything ready at once
    task automatic drive_txn(input int idx);
        mreq[idx] = rnd_req(); mvalid = '0; mvalid[idx] = 1'b1;
        sreq_ready = 1'b1; mresp_ready = '1;
        tick(); mvalid = '0;
        tick(); sresp_valid = 1'b1;
        tick(); sresp_valid = 1'b0; sreq_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        n_tests++; if (sreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sreq_valid: got %b want 0", sreq_valid); end
        n_tests++; if (sreq !== 41'h0) begin n_fail++; $display("FAIL reset_sreq: got %h want 0", sreq); end
        n_tests++; if (sresp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sresp_ready: got %b want 0", sresp_ready); end
        n_tests++; if (mresp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_mresp_valid: got %b want 00", mresp_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %b want 0", owner); end
        n_tests++; if (mready !== 2'b00) begin n_fail++; $display("FAIL reset_mready: got %b want 00", mready); end
        tick(); rst_ni = 1'b1;
    endtask

    task automatic test_single();
        logic [40:0] exp;
        apply_reset();
        exp = {7'h10, 2'd2, 32'hDEADBEEF};
        mreq[1] = exp; mvalid = 2'b10; sreq_ready = 1'b1;
        @(negedge clk_i);
        n_tests++; if (mready !== 2'b10) begin n_fail++; $display("FAIL single_grant: got %b want 10", mready); end
        tick(); mvalid = '0;
        @(negedge clk_i);
        n_tests++; if (sreq_valid !== 1'b1) begin n_fail++; $display("FAIL single_sreq_valid: got %b want 1", sreq_valid); end
        n_tests++; if (sreq !== exp) begin n_fail++; $display("FAIL single_sreq: got %h want %h", sreq, exp); end
        n_tests++; if (owner !== 1'b1) begin n_fail++; $display("FAIL single_owner: got %b want 1", owner); end
        tick(); sreq_ready = 1'b0; sresp = '0; sresp_valid = 1'b1; mresp_ready = 2'b10;
        @(negedge clk_i);
        n_tests++; if (mresp_valid !== 2'b10) begin n_fail++; $display("FAIL single_mresp_valid: got %b want 10", mresp_valid); end
        n_tests++; if (sresp_ready !== 1'b1) begin n_fail++; $display("FAIL single_sresp_ready: got %b want 1", sresp_ready); end
        n_tests++; if (mresp[1] !== 34'h0) begin n_fail++; $display("FAIL single_mresp_data: got %h want 0", mresp[1]); end
        tick(); sresp_valid = 1'b0;
        @(negedge clk_i);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        int g;
        int want;
        apply_reset();
        mreq[0] = rnd_req(); mreq[1] = rnd_req();
        mvalid = 2'b11; sreq_ready = 1'b1; sresp_valid = 1'b1; mresp_ready = 2'b11;
        g = 0;
        for (int c = 0; c < 40 && g < 4; c++) begin
            @(negedge clk_i);
            n_tests++; if (mready === 2'b11) begin n_fail++; $display("FAIL simul_onehot: got %b want at most one bit", mready); end
            if (mready !== 2'b00) begin
                want = g % 2;
                n_tests++; if (int'(mready[1]) !== want) begin n_fail++; $display("FAIL simul_order: grant %0d got %b want index %0d", g, mready, want); end
                g++;
            end
        end
        n_tests++; if (g != 4) begin n_fail++; $display("FAIL simul_timeout: got %0d grants want 4", g); end
        tick(); clear_inputs();
    endtask

    task automatic test_slave_backpressure();
        logic [40:0] exp;
        apply_reset();
        exp = rnd_req();
        mreq[0] = exp; mvalid = 2'b01;
        @(negedge clk_i);
        n_tests++; if (mready !== 2'b01) begin n_fail++; $display("FAIL sbp_grant: got %b want 01", mready); end
        tick(); mvalid = 2'b11; mreq[0] = ~exp; mreq[1] = rnd_req(); sreq_ready = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            n_tests++; if (sreq_valid !== 1'b1) begin n_fail++; $display("FAIL sbp_valid: got %b want 1", sreq_valid); end
            n_tests++; if (sreq !== exp) begin n_fail++; $display("FAIL sbp_stable: got %h want %h", sreq, exp); end
            n_tests++; if (mready !== 2'b00) begin n_fail++; $display("FAIL sbp_no_grant: got %b want 00", mready); end
        end
        tick(); sreq_ready = 1'b1; mvalid = '0;
        tick(); sreq_ready = 1'b0; sresp_valid = 1'b1; mresp_ready = 2'b01;
        @(negedge clk_i);
        n_tests++; if (mresp_valid !== 2'b01) begin n_fail++; $display("FAIL sbp_resp: got %b want 01", mresp_valid); end
        tick(); clear_inputs();
    endtask

    task automatic test_requester_backpressure();
        logic [33:0] rd;
        apply_reset();
        rd = {$urandom, 2'($urandom)};
        mreq[0] = rnd_req(); mvalid = 2'b01; sreq_ready = 1'b1;
        tick(); mvalid = '0;
        tick(); sreq_ready = 1'b0; sresp = rd; sresp_valid = 1'b1; mresp_ready = 2'b10;
        repeat (3) begin
            @(negedge clk_i);
            n_tests++; if (sresp_ready !== 1'b0) begin n_fail++; $display("FAIL rbp_sresp_ready: got %b want 0", sresp_ready); end
            n_tests++; if (mresp_valid !== 2'b01) begin n_fail++; $display("FAIL rbp_route: got %b want 01", mresp_valid); end
            n_tests++; if (mresp[0] !== rd) begin n_fail++; $display("FAIL rbp_data: got %h want %h", mresp[0], rd); end
        end
        tick(); mresp_ready = 2'b11;
        @(negedge clk_i);
        n_tests++; if (sresp_ready !== 1'b1) begin n_fail++; $display("FAIL rbp_release: got %b want 1", sresp_ready); end
        n_tests++; if (mresp_valid !== 2'b01) begin n_fail++; $display("FAIL rbp_deliver: got %b want 01", mresp_valid); end
        tick(); sresp_valid = 1'b0;
        @(negedge clk_i);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rbp_done: got %b want 0", busy); end
        clear_inputs();
    endtask

    task automatic test_spurious();
        apply_reset();
        sresp_valid = 1'b1; sresp = {$urandom, 2'b01}; mresp_ready = 2'b11;
        repeat (3) begin
            @(negedge clk_i);
            n_tests++; if (sresp_ready !== 1'b0) begin n_fail++; $display("FAIL spur_ready: got %b want 0", sresp_ready); end
            n_tests++; if (mresp_valid !== 2'b00) begin n_fail++; $display("FAIL spur_valid: got %b want 00", mresp_valid); end
        end
        // Still held off while the request is waiting for the slave
        mvalid = 2'b10;
        tick(); mvalid = '0;
        @(negedge clk_i);
        n_tests++; if (sresp_ready !== 1'b0) begin n_fail++; $display("FAIL spur_req_ready: got %b want 0", sresp_ready); end
        n_tests++; if (mresp_valid !== 2'b00) begin n_fail++; $display("FAIL spur_req_valid: got %b want 00", mresp_valid); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive_txn(0);                   // round-robin pointer now favours requester 1
        mreq[0] = rnd_req(); mvalid = 2'b01;
        tick(); mvalid = '0;
        @(negedge clk_i);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_in_req: got %b want 1", busy); end
        sresp_valid = 1'b1;
        #1 rst_ni = 1'b0;
        #1;
        n_tests++; if (sreq_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_sreq_valid: got %b want 0", sreq_valid); end
        n_tests++; if (sreq !== 41'h0) begin n_fail++; $display("FAIL rmid_sreq: got %h want 0", sreq); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_tests++; if (owner !== 1'b0) begin n_fail++; $display("FAIL rmid_owner: got %b want 0", owner); end
        n_tests++; if (sresp_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_sresp_ready: got %b want 0", sresp_ready); end
        tick(); clear_inputs(); rst_ni = 1'b1; mvalid = 2'b11;
        @(negedge clk_i);
        n_tests++; if (mready !== 2'b01) begin n_fail++; $display("FAIL rmid_first_grant: got %b want 01", mready); end
        tick(); clear_inputs();
    endtask

    // Randomized traffic against a transaction-level model
    task automatic test_random();
        int          ptr, w, eown, ntx;
        bit          outst, acc, found;
        logic [40:0] ereq;
        logic [1:0]  eready, eresp;
        apply_reset();
        ptr = 0; outst = 0; acc = 0; eown = 0; ntx = 0; ereq = '0;
        for (int c = 0; c < 500; c++) begin
            mvalid = 2'($urandom); mreq[0] = rnd_req(); mreq[1] = rnd_req();
            sreq_ready = 1'($urandom); sresp_valid = 1'($urandom);
            sresp = {$urandom, 2'($urandom)}; mresp_ready = 2'($urandom);
            @(negedge clk_i);
            if (!outst) begin
                found = 0; w = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && mvalid[(ptr + k) % N]) begin found = 1; w = (ptr + k) % N; end
                end
                eready = '0; if (found) eready[w] = 1'b1;
                n_tests++; if (mready !== eready) begin n_fail++; $display("FAIL rnd_grant c=%0d: got %b want %b", c, mready, eready); end
                n_tests++; if (busy !== 1'b0 || sreq_valid !== 1'b0 || sresp_ready !== 1'b0 || mresp_valid !== 2'b00) begin
                    n_fail++; $display("FAIL rnd_idle c=%0d: got busy=%b sv=%b sr=%b mv=%b want 0 0 0 00", c, busy, sreq_valid, sresp_ready, mresp_valid);
                end
                if (found) begin outst = 1; ereq = mreq[w]; eown = w; end
            end else if (!acc) begin
                n_tests++; if (sreq_valid !== 1'b1 || sreq !== ereq) begin n_fail++; $display("FAIL rnd_req c=%0d: got v=%b %h want 1 %h", c, sreq_valid, sreq, ereq); end
                n_tests++; if (mready !== 2'b00 || int'(owner) !== eown || sresp_ready !== 1'b0 || mresp_valid !== 2'b00) begin
                    n_fail++; $display("FAIL rnd_reqside c=%0d: got mr=%b own=%0d sr=%b mv=%b want 00 %0d 0 00", c, mready, owner, sresp_ready, mresp_valid, eown);
                end
                if (sreq_ready) begin acc = 1; ptr = (eown + 1) % N; end
            end else begin
                eresp = '0; if (sresp_valid) eresp[eown] = 1'b1;
                n_tests++; if (mresp_valid !== eresp) begin n_fail++; $display("FAIL rnd_resp_valid c=%0d: got %b want %b", c, mresp_valid, eresp); end
                n_tests++; if (sresp_ready !== mresp_ready[eown]) begin n_fail++; $display("FAIL rnd_resp_ready c=%0d: got %b want %b", c, sresp_ready, mresp_ready[eown]); end
                n_tests++; if (sreq_valid !== 1'b0 || mready !== 2'b00) begin n_fail++; $display("FAIL rnd_respside c=%0d: got sv=%b mr=%b want 0 00", c, sreq_valid, mready); end
                if (sresp_valid && mresp_ready[eown]) begin outst = 0; acc = 0; ntx++; end
            end
            tick();
        end
        n_tests++; if (ntx < 10) begin n_fail++; $display("FAIL rnd_progress: got %0d transactions want at least 10", ntx); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_slave_backpressure();
        test_requester_backpressure();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Shares the single core-side DMI request/response channel (the clock-domain-crossed DMI feeding the debug module) between `NrMasters` DMI requesters, e.g. the JTAG DTM and an on-chip debug host. Round-robin arbitration; exactly one transaction outstanding. The block remembers the owner and routes the response back to that requester only. Sits in the `clk_i` domain between the requesters and the debug module's DMI slave port.

## Interface
- `NrMasters`, default 2: number of DMI requesters, minimum 2.
- `IdxW`, default `$clog2(NrMasters)`: owner index width. Derived; not overridden.

Ports:
- `clk_i` in 1: core clock; single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `mst_req_i` in `NrMasters` x `dm::dmi_req_t`: requester requests (addr 7, op 2, data 32).
- `mst_req_valid_i` in `NrMasters`: request valid per requester.
- `mst_req_ready_o` out `NrMasters`: request accepted per requester.
- `mst_resp_o` out `NrMasters` x `dm::dmi_resp_t`: response (data 32, resp 2). `slv_resp_i` is broadcast to all entries.
- `mst_resp_valid_o` out `NrMasters`: response valid. Only the owner's bit is ever set.
- `mst_resp_ready_i` in `NrMasters`: response ready per requester.
- `slv_req_o` out `dm::dmi_req_t`: registered request to the debug module.
- `slv_req_valid_o` out 1: request valid to the debug module.
- `slv_req_ready_i` in 1: debug module accepts the request.
- `slv_resp_i` in `dm::dmi_resp_t`: response from the debug module.
- `slv_resp_valid_i` in 1: response valid.
- `slv_resp_ready_o` out 1: response ready.
- `busy_o` out 1: high whenever state is not IDLE.
- `owner_o` out `IdxW`: index of the current or last granted requester.

## Operation
Three-state FSM: IDLE, REQ, RESP. Registers: `state_q`, `req_q` (the `dmi_req_t`), `owner_q`, and the round-robin pointer `prio_q` (`IdxW` bits).

- **IDLE**
  - Scan `mst_req_valid_i` starting at index `prio_q`, wrapping modulo `NrMasters`. The first set bit wins.
  - `mst_req_ready_o[winner]` = 1. All other ready bits = 0. This ready is combinational on the valids; valid never depends on ready.
  - On a handshake: `req_q` <= `mst_req_i[winner]`, `owner_q` <= winner, go to REQ.
  - No valid set: stay in IDLE.
- **REQ**
  - `slv_req_valid_o` = 1. `slv_req_o` = `req_q`, held stable until accepted.
  - All `mst_req_ready_o` = 0.
  - On `slv_req_ready_i`: go to RESP. `prio_q` <= (`owner_q` + 1) mod `NrMasters`. The increment wraps explicitly for non-power-of-2 `NrMasters`.
- **RESP**
  - `mst_resp_valid_o[owner_q]` = `slv_resp_valid_i`.
  - `slv_resp_ready_o` = `mst_resp_ready_i[owner_q]`.
  - On a handshake: go to IDLE.
- **Outside RESP:** `slv_resp_ready_o` = 0 and all `mst_resp_valid_o` = 0. An early or spurious slave response is back-pressured and is never dropped or misrouted.
- **Non-owner requesters:** `mst_resp_ready_i` from non-owners is ignored.
- **Fairness:** a requester that keeps its valid high is served within `NrMasters` transactions.
- **Op field:** the `op` field is forwarded unmodified, NOP included. The arbiter does not interpret it.

## Timing
- **Reset** (asynchronous assert, synchronous-to-`clk_i` release is external):
  - `state_q`=IDLE, `prio_q`=0, `owner_q`=0, `req_q`='0.
  - Resulting outputs: `slv_req_valid_o`=0, `slv_req_o`='0, `slv_resp_ready_o`=0, `mst_resp_valid_o`='0, `busy_o`=0, `owner_o`=0.
  - `mst_req_ready_o` is combinational on `mst_req_valid_i` in IDLE; it is 0 while all valids are low.
- **Request latency:** requester handshake in cycle N gives `slv_req_valid_o` high in N+1.
- **Response path:** combinational, zero added latency. `slv_resp_valid_i` in cycle M raises `mst_resp_valid_o[owner]` in cycle M.
- **Minimum transaction:** 3 cycles (IDLE, REQ, RESP), with the slave ready at once and the response in the cycle after acceptance.
- **Back-to-back:** response handshake in cycle M leads to IDLE in M+1, next grant in M+1, and the next `slv_req_valid_o` in M+2.
- **Reset mid-transaction:** the FSM returns to IDLE immediately and the outstanding response is abandoned. The system resets the debug module and CDC with it.

## Test plan
- **Single request:** requester 1 sends addr 0x10, op 2 (write), data 0xDEADBEEF; slave ready immediately; response data 0, resp 0 one cycle later.
  - `slv_req_o` matches the request exactly; `owner_o`=1.
  - `mst_resp_valid_o`=2'b10; transaction takes 3 cycles; `busy_o` then drops.
- **Simultaneous requests:** both requesters hold valid continuously out of reset (`prio_q`=0).
  - Grants alternate 0,1,0,1 over four transactions.
  - `mst_req_ready_o` is never high for both bits in one cycle.
- **Slave back-pressure:** `slv_req_ready_i` held low for 5 cycles.
  - `slv_req_o` stays stable and valid for all 5 cycles.
  - No further `mst_req_ready_o` is asserted.
- **Requester back-pressure:** in RESP, owner 0 holds `mst_resp_ready_i`=0 for 3 cycles while requester 1 holds ready=1.
  - `slv_resp_ready_o` stays 0 for those 3 cycles; `mst_resp_valid_o[1]` stays 0.
  - The response is delivered only to requester 0.
- **Spurious response:** `slv_resp_valid_i`=1 asserted in IDLE.
  - `slv_resp_ready_o`=0 and no `mst_resp_valid_o` is asserted.
- **Reset mid-operation:** `rst_ni` asserted while in REQ.
  - All outputs take their reset values in the same cycle; `prio_q`=0.
  - The first grant after release goes to requester 0.
